data_mem_be: RTL and testbench

Parametrised byte-addressable data memory for the single-cycle MIPS datapath, sitting behind the ALU address output and feeding the write-back mux. It extends the word-only data memory with byte, halfword and word loads and stores, sign or zero extension on loads, and a post-reset clear sequencer that initialises every word in hardware instead of relying on a simulation-only initial block. An optional alignment checker flags and suppresses misaligned accesses.

---
 rtl/dmem_pkg.sv | 38 +++
 rtl/data_mem_be_if.sv | 25 ++
 rtl/dmem_load_align.sv | 29 ++
 rtl/data_mem_be.sv | 105 ++++++++++
 tb/tb_data_mem_be.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-enabled data memory: access size encodings,
// clear/ready FSM states and the store lane-enable helpers.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dmem_state_e;

  // Byte-lane enables for a store; half uses addr[1] only and word ignores
  // the low address bits, so unaligned accesses land on the containing lanes.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] addr);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << addr;
      SZ_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicates right-justified store data across all lanes so the byte
  // enables alone select what is written.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] d;
    case (size)
      SZ_BYTE: d = {4{wd[7:0]}};
      SZ_HALF: d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/data_mem_be_if.sv
// Bus between the datapath (master) and the data memory (slave).
// Handshake: there is no valid/ready pair; mem_write is a one-cycle store
// request sampled at posedge, mem_read qualifies the combinational read_data,
// and busy=1 means the memory is clearing and will neither store nor load.
interface data_mem_be_if;
  logic [31:0] addr_in;
  logic [31:0] write_data;
  logic        mem_write;
  logic        mem_read;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] read_data;
  logic        busy;
  logic        misalign;

  modport master (
    output addr_in, write_data, mem_write, mem_read, size, sign_ext,
    input  read_data, busy, misalign
  );

  modport slave (
    input  addr_in, write_data, mem_write, mem_read, size, sign_ext,
    output read_data, busy, misalign
  );
endinterface

// File: rtl/dmem_load_align.sv
// Load path: picks the addressed byte/half/word out of a stored word and
// sign- or zero-extends it to 32 bits. Purely combinational.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr,
  input  logic [1:0]  i_size,
  input  logic        i_sign_ext,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_addr, 3'b000} +: 8];
  assign w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];

  // Extend the selected lane(s); word loads pass straight through.
  always_comb begin
    o_data = i_word;
    case (i_size)
      SZ_BYTE: o_data = {{24{i_sign_ext & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{i_sign_ext & w_half[15]}}, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/data_mem_be.sv
// Byte-addressable data memory with byte/half/word loads and stores and a
// hardware clear sequencer that initialises every word after reset.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (flags misaligned accesses,
// suppresses flagged stores and zeroes flagged loads).
module data_mem_be
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 5,
  parameter int INIT_MODE  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  data_mem_be_if.slave  bus,
  output dmem_state_e   o_dbg_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           r_mem [DEPTH];
  dmem_state_e           r_state;
  logic [DEPTH_LOG2-1:0] r_cnt;
  logic                  r_busy;

  logic [DEPTH_LOG2-1:0] w_idx;
  logic [31:0]           w_init;
  logic                  w_misalign;
  logic                  w_store;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata;
  logic [31:0]           w_rword;
  logic [31:0]           w_load;
  logic [31-DEPTH_LOG2-2:0] w_unused_addr;

  // Upper address bits alias onto the array and are deliberately dropped.
  assign w_unused_addr = bus.addr_in[31:DEPTH_LOG2+2];
  assign w_idx         = bus.addr_in[DEPTH_LOG2+1:2];
  assign w_init        = (INIT_MODE != 0) ? 32'(r_cnt) : 32'd0;

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_misalign = !r_busy && (bus.mem_read || bus.mem_write) &&
                      (((bus.size == SZ_HALF) && bus.addr_in[0]) ||
                       (bus.size[1] && (bus.addr_in[1:0] != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_store = (r_state == READY) && bus.mem_write && !w_misalign;
  assign w_be    = lane_be(bus.size, bus.addr_in[1:0]);
  assign w_wdata = store_lanes(bus.size, bus.write_data);

  // Clear sequencer: walk the counter over every word, then hold READY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (&r_cnt) begin
            r_state <= READY;
            r_busy  <= 1'b0;
          end
        end
        READY: begin
          r_state <= READY;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= CLEAR;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  // Storage: the clear value goes in while clearing, otherwise lane-merged stores.
  always_ff @(posedge clk) begin
    if (r_state == CLEAR) begin
      r_mem[r_cnt] <= w_init;
    end else if (w_store) begin
      for (int l = 0; l < 4; l++) begin
        if (w_be[l]) r_mem[w_idx][8*l +: 8] <= w_wdata[8*l +: 8];
      end
    end
  end

  assign w_rword = r_mem[w_idx];

  dmem_load_align u_load_align (
    .i_word     (w_rword),
    .i_addr     (bus.addr_in[1:0]),
    .i_size     (bus.size),
    .i_sign_ext (bus.sign_ext),
    .o_data     (w_load)
  );

  assign bus.read_data = (r_busy || !bus.mem_read || w_misalign) ? 32'd0 : w_load;
  assign bus.busy      = r_busy;
  assign bus.misalign  = w_misalign;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_data_mem_be.sv
// Self-checking bench for data_mem_be (DEPTH_LOG2=5, INIT_MODE=1) with a
// byte-array reference model of the little-endian memory.
module tb_data_mem_be;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  dmem_state_e dbg_state;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  bm [128];
  logic [31:0] exp_q [$];

  data_mem_be_if bus ();

  data_mem_be #(.DEPTH_LOG2(5), .INIT_MODE(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void model_clear();
    for (int i = 0; i < 32; i++)
      for (int b = 0; b < 4; b++) bm[i*4+b] = 8'((i >> (8*b)) & 255);
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_mis(input logic [31:0] a, input logic [1:0] sz, input logic re, input logic we);
`ifdef DMEM_ALIGN_CHECK_EN
    return (re || we) && ((sz == 2'd1 && (a % 2) != 0) || (sz >= 2'd2 && (a % 4) != 0));
`else
    return 1'b0;
`endif
  endfunction

  function automatic int ebase(input logic [31:0] a, input logic [1:0] sz);
    int x;
    x = int'(a % 128);
    return x - (x % nbytes(sz));
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic sx, input logic re, input logic we);
    logic [31:0] v;
    int n, b;
    if (!re || model_mis(a, sz, re, we)) return 32'd0;
    n = nbytes(sz);
    b = ebase(a, sz);
    v = 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(bm[b+k]) << (8*k));
    if (sx && n == 1 && v[7])  v = v | 32'hFFFFFF00;
    if (sx && n == 2 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [1:0] sz,
                                      input logic [31:0] wd, input logic we, input logic re);
    int n, b;
    if (!we || model_mis(a, sz, re, we)) return;
    n = nbytes(sz);
    b = ebase(a, sz);
    for (int k = 0; k < n; k++) bm[b+k] = 8'((wd >> (8*k)) & 32'hFF);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b0;
  endtask

  task automatic drive_op(input logic [31:0] a, input logic [31:0] wd, input logic we,
                          input logic re, input logic [1:0] sz, input logic sx,
                          output logic [31:0] rd, output logic mis);
    @(negedge clk);
    bus.addr_in = a; bus.write_data = wd; bus.mem_write = we;
    bus.mem_read = re; bus.size = sz; bus.sign_ext = sx;
    #1;
    rd  = bus.read_data;
    mis = bus.misalign;
    @(posedge clk);
    model_store(a, sz, wd, we, re);
    #1;
    idle();
  endtask

  // Counts posedges from release until busy drops; returns 999 on timeout.
  task automatic count_busy(output int n);
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (bus.busy !== 1'b1) break;
      if (n == 16) begin
        n_cmp++;
        if (bus.read_data !== 32'd0) begin
          n_err++; $display("FAIL busy_read_zero: got %h want %h", bus.read_data, 32'd0);
        end
      end
    end
    idle();
    if (n >= 100) n = 999;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] rd; logic mis; int n;
    rst_n = 1'b0;
    bus.addr_in = 32'h2; bus.write_data = 32'hDEADBEEF; bus.mem_write = 1'b1;
    bus.mem_read = 1'b1; bus.size = SZ_WORD; bus.sign_ext = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rst_busy: got %b want 1", bus.busy); end
    n_cmp++; if (bus.read_data !== 32'd0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", bus.read_data); end
    n_cmp++; if (bus.misalign !== 1'b0) begin n_err++; $display("FAIL rst_misalign: got %b want 0", bus.misalign); end
    n_cmp++; if (dbg_state !== CLEAR) begin n_err++; $display("FAIL rst_state: got %0d want CLEAR", dbg_state); end
    rst_n = 1'b1;
    count_busy(n);
    n_cmp++; if (n != 32) begin n_err++; $display("FAIL clear_len: got %0d want 32", n); end
    model_clear();
    drive_op(32'h00, 32'd0, 1'b0, 1'b1, SZ_WORD, 1'b0, rd, mis);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL busy_store_ignored: got %h want 00000000", rd); end
    drive_op(32'h1C, 32'd0, 1'b0, 1'b1, SZ_WORD, 1'b0, rd, mis);
    n_cmp++; if (rd !== 32'h7) begin n_err++; $display("FAIL init_word7: got %h want 00000007", rd); end
  endtask

  task automatic test_directed();
    logic [31:0] rd; logic mis;
    drive_op(32'h40, 32'h11223344, 1'b1, 1'b0, SZ_WORD, 1'b0, rd, mis);
    drive_op(32'h41, 32'd0, 1'b0, 1'b1, SZ_BYTE, 1'b1, rd, mis);
    n_cmp++; if (rd !== 32'h33) begin n_err++; $display("FAIL lb_41: got %h want 00000033", rd); end
    drive_op(32'h42, 32'd0, 1'b0, 1'b1, SZ_HALF, 1'b1, rd, mis);
    n_cmp++; if (rd !== 32'h1122) begin n_err++; $display("FAIL lh_42: got %h want 00001122", rd); end
    drive_op(32'h40, 32'd0, 1'b0, 1'b1, SZ_WORD, 1'b1, rd, mis);
    n_cmp++; if (rd !== 32'h11223344) begin n_err++; $display("FAIL lw_40: got %h want 11223344", rd); end
    drive_op(32'h43, 32'h80, 1'b1, 1'b0, SZ_BYTE, 1'b0, rd, mis);
    drive_op(32'h43, 32'd0, 1'b0, 1'b1, SZ_BYTE, 1'b1, rd, mis);
    n_cmp++; if (rd !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_43_sx: got %h want ffffff80", rd); end
    drive_op(32'h43, 32'd0, 1'b0, 1'b1, SZ_BYTE, 1'b0, rd, mis);
    n_cmp++; if (rd !== 32'h80) begin n_err++; $display("FAIL lbu_43: got %h want 00000080", rd); end
    drive_op(32'h40, 32'd0, 1'b0, 1'b1, SZ_WORD, 1'b0, rd, mis);
    n_cmp++; if (rd !== 32'h80223344) begin n_err++; $display("FAIL lw_40_after_sb: got %h want 80223344", rd); end
    drive_op(32'h06, 32'h0000BEEF, 1'b1, 1'b0, SZ_HALF, 1'b0, rd, mis);
    drive_op(32'h04, 32'd0, 1'b0, 1'b1, SZ_WORD, 1'b0, rd, mis);
    n_cmp++; if (rd !== 32'hBEEF0001) begin n_err++; $display("FAIL lw_04_after_sh: got %h want beef0001", rd); end
    drive_op(32'h06, 32'd0, 1'b0, 1'b1, SZ_HALF, 1'b1, rd, mis);
    n_cmp++; if (rd !== 32'hFFFFBEEF) begin n_err++; $display("FAIL lh_06_sx: got %h want ffffbeef", rd); end
    // Simultaneous read and write: the load sees the pre-edge word.
    drive_op(32'h04, 32'h12345678, 1'b1, 1'b1, SZ_WORD, 1'b0, rd, mis);
    n_cmp++; if (rd !== 32'hBEEF0001) begin n_err++; $display("FAIL rw_same_cycle: got %h want beef0001", rd); end
    drive_op(32'h04, 32'd0, 1'b0, 1'b1, SZ_WORD, 1'b0, rd, mis);
    n_cmp++; if (rd !== 32'h12345678) begin n_err++; $display("FAIL rw_after_edge: got %h want 12345678", rd); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic mis;
    drive_op(32'h02, 32'hCAFEF00D, 1'b1, 1'b0, SZ_WORD, 1'b0, rd, mis);
`ifdef DMEM_ALIGN_CHECK_EN
    n_cmp++; if (mis !== 1'b1) begin n_err++; $display("FAIL sw_02_misalign: got %b want 1", mis); end
    drive_op(32'h00, 32'd0, 1'b0, 1'b1, SZ_WORD, 1'b0, rd, mis);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL sw_02_suppressed: got %h want 00000000", rd); end
    drive_op(32'h03, 32'd0, 1'b0, 1'b1, SZ_HALF, 1'b0, rd, mis);
    n_cmp++; if (mis !== 1'b1) begin n_err++; $display("FAIL lh_03_misalign: got %b want 1", mis); end
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL lh_03_zero: got %h want 00000000", rd); end
`else
    n_cmp++; if (mis !== 1'b0) begin n_err++; $display("FAIL sw_02_misalign: got %b want 0", mis); end
    drive_op(32'h00, 32'd0, 1'b0, 1'b1, SZ_WORD, 1'b0, rd, mis);
    n_cmp++; if (rd !== 32'hCAFEF00D) begin n_err++; $display("FAIL sw_02_word0: got %h want cafef00d", rd); end
    drive_op(32'h03, 32'd0, 1'b0, 1'b1, SZ_HALF, 1'b0, rd, mis);
    n_cmp++; if (rd !== 32'h0000CAFE) begin n_err++; $display("FAIL lh_03_upper: got %h want 0000cafe", rd); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] rd, a, wd, exp_v; logic mis, exp_m, we, re, sx; logic [1:0] sz;
    for (int i = 0; i < 300; i++) begin
      a  = 32'($urandom_range(0, 255));
      wd = $urandom;
      sz = 2'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      sx = 1'($urandom_range(0, 1));
      exp_q.push_back(model_load(a, sz, sx, re, we));
      exp_m = model_mis(a, sz, re, we);
      drive_op(a, wd, we, re, sz, sx, rd, mis);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (rd !== exp_v) begin
        n_err++; $display("FAIL rand_load[%0d] a=%h sz=%0d: got %h want %h", i, a, sz, rd, exp_v);
      end
      n_cmp++;
      if (mis !== exp_m) begin
        n_err++; $display("FAIL rand_misalign[%0d]: got %b want %b", i, mis, exp_m);
      end
    end
  endtask

  task automatic test_mid_clear_reset();
    logic [31:0] rd; logic mis; int n;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL midclear_busy: got %b want 1", bus.busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (dbg_state !== CLEAR) begin n_err++; $display("FAIL midclear_state: got %0d want CLEAR", dbg_state); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL midclear_busy_rst: got %b want 1", bus.busy); end
    @(negedge clk); rst_n = 1'b1;
    count_busy(n);
    n_cmp++; if (n != 32) begin n_err++; $display("FAIL restart_clear_len: got %0d want 32", n); end
    model_clear();
    drive_op(32'h40, 32'd0, 1'b0, 1'b1, SZ_WORD, 1'b0, rd, mis);
    n_cmp++; if (rd !== 32'h10) begin n_err++; $display("FAIL restart_word16: got %h want 00000010", rd); end
    drive_op(32'h7C, 32'd0, 1'b0, 1'b1, SZ_WORD, 1'b0, rd, mis);
    n_cmp++; if (rd !== 32'h1F) begin n_err++; $display("FAIL restart_word31: got %h want 0000001f", rd); end
  endtask

  task automatic test_alias();
    logic [31:0] rd; logic mis;
    drive_op(32'h80, 32'h13579BDF, 1'b1, 1'b0, SZ_WORD, 1'b0, rd, mis);
    drive_op(32'h00, 32'd0, 1'b0, 1'b1, SZ_WORD, 1'b0, rd, mis);
    n_cmp++; if (rd !== 32'h13579BDF) begin n_err++; $display("FAIL alias_80_to_0: got %h want 13579bdf", rd); end
    drive_op(32'h1000_0084, 32'd0, 1'b0, 1'b1, SZ_WORD, 1'b0, rd, mis);
    n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL alias_high_bits: got %h want 00000001", rd); end
  endtask

  initial begin
    bus.addr_in = '0; bus.write_data = '0; bus.size = SZ_WORD; bus.sign_ext = 1'b0;
    idle();
    test_reset();
    test_directed();
    test_misalign();
    test_random();
    test_mid_clear_reset();
    test_alias();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
